// File: rtl/id_ex_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_if
// Description : Bundles the decode-side, forwarding-source and EX-side signals
//               of the ID/EX pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
interface id_ex_stage_if #(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 8
);
  // Hazard / branch control
  logic              Stall;
  logic              Flush;
  // Decode slot
  logic              InValid;
  logic [3:0]        Rs;
  logic [3:0]        Rt;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  logic [DATA_W-1:0] Imm;
  logic [CTRL_W-1:0] CtrlIn;
  logic              RegWreIn;
  logic [3:0]        WriteRegIn;
  logic              MemReadIn;
  logic [DATA_W-1:0] PcIn;
  // Forwarding sources
  logic              ExRegWre;
  logic              ExMemRead;
  logic [3:0]        ExWriteReg;
  logic [DATA_W-1:0] ExResult;
  logic              MemRegWre;
  logic [3:0]        MemWriteReg;
  logic [DATA_W-1:0] MemResult;
  // EX slot
  logic              LoadUseStall;
  logic              OutValid;
  logic [DATA_W-1:0] OpA;
  logic [DATA_W-1:0] OpB;
  logic [DATA_W-1:0] ImmOut;
  logic [DATA_W-1:0] PcOut;
  logic [CTRL_W-1:0] CtrlOut;
  logic              RegWreOut;
  logic              MemReadOut;
  logic [3:0]        WriteRegOut;
  logic [1:0]        FwdA;
  logic [1:0]        FwdB;

  modport master (
    output Stall, Flush, InValid, Rs, Rt, ReadData1, ReadData2, Imm, CtrlIn,
           RegWreIn, WriteRegIn, MemReadIn, PcIn, ExRegWre, ExMemRead,
           ExWriteReg, ExResult, MemRegWre, MemWriteReg, MemResult,
    input  LoadUseStall, OutValid, OpA, OpB, ImmOut, PcOut, CtrlOut,
           RegWreOut, MemReadOut, WriteRegOut, FwdA, FwdB
  );

  modport slave (
    input  Stall, Flush, InValid, Rs, Rt, ReadData1, ReadData2, Imm, CtrlIn,
           RegWreIn, WriteRegIn, MemReadIn, PcIn, ExRegWre, ExMemRead,
           ExWriteReg, ExResult, MemRegWre, MemWriteReg, MemResult,
    output LoadUseStall, OutValid, OpA, OpB, ImmOut, PcOut, CtrlOut,
           RegWreOut, MemReadOut, WriteRegOut, FwdA, FwdB
  );
endinterface
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register with EX/MEM operand forwarding,
//               T-register compare semantics, load-use hazard detection and
//               stall/flush control.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
  parameter int         DATA_W   = 16,
  parameter int         CTRL_W   = 8,
  parameter logic [3:0] REG0_IDX = 4'h0,
  parameter logic [3:0] T_IDX    = 4'hE,
  parameter logic [3:0] PC_IDX   = 4'hF
) (
  input  logic          Clk,
  input  logic          Rst,
  id_ex_stage_if.slave  bus
);

  localparam logic [1:0] C_SEL_RF  = 2'd0;
  localparam logic [1:0] C_SEL_MEM = 2'd1;
  localparam logic [1:0] C_SEL_EX  = 2'd2;

  // The register file stores only the zero flag into T, so a forwarded value
  // aimed at T must be reduced the same way.
  function automatic logic [DATA_W-1:0] t_view(input logic [3:0] dst,
                                               input logic [DATA_W-1:0] res);
    if (dst == T_IDX) return {{(DATA_W-1){1'b0}}, (res == '0)};
    return res;
  endfunction

  logic              w_src_ok_a, w_src_ok_b;
  logic              w_ex_hit_a, w_ex_hit_b, w_mem_hit_a, w_mem_hit_b;
  logic [DATA_W-1:0] w_ex_val, w_mem_val;
  logic [DATA_W-1:0] w_op_a, w_op_b;
  logic [1:0]        w_fwd_a, w_fwd_b;

  logic              r_valid, r_regwre, r_memread;
  logic [DATA_W-1:0] r_op_a, r_op_b, r_imm, r_pc;
  logic [CTRL_W-1:0] r_ctrl;
  logic [3:0]        r_wreg;
  logic [1:0]        r_fwd_a, r_fwd_b;

  // REG0 and PC are never produced by an in-flight instruction.
  assign w_src_ok_a  = (bus.Rs != REG0_IDX) && (bus.Rs != PC_IDX);
  assign w_src_ok_b  = (bus.Rt != REG0_IDX) && (bus.Rt != PC_IDX);
  assign w_ex_hit_a  = w_src_ok_a && bus.ExRegWre  && (bus.ExWriteReg  == bus.Rs);
  assign w_ex_hit_b  = w_src_ok_b && bus.ExRegWre  && (bus.ExWriteReg  == bus.Rt);
  assign w_mem_hit_a = w_src_ok_a && bus.MemRegWre && (bus.MemWriteReg == bus.Rs);
  assign w_mem_hit_b = w_src_ok_b && bus.MemRegWre && (bus.MemWriteReg == bus.Rt);
  assign w_ex_val    = t_view(bus.ExWriteReg,  bus.ExResult);
  assign w_mem_val   = t_view(bus.MemWriteReg, bus.MemResult);

  // A load still in EX cannot supply its data yet; ask the hazard unit to hold.
  assign bus.LoadUseStall = bus.InValid && bus.ExMemRead && bus.ExRegWre &&
                            ((w_src_ok_a && (bus.ExWriteReg == bus.Rs)) ||
                             (w_src_ok_b && (bus.ExWriteReg == bus.Rt)));

  // Operand A mux: youngest producer (EX) wins over MEM, then the register file.
  always_comb begin
    w_op_a  = bus.ReadData1;
    w_fwd_a = C_SEL_RF;
    if (w_ex_hit_a) begin
      w_op_a  = w_ex_val;
      w_fwd_a = C_SEL_EX;
    end else if (w_mem_hit_a) begin
      w_op_a  = w_mem_val;
      w_fwd_a = C_SEL_MEM;
    end
  end

  // Operand B mux: same priority as operand A.
  always_comb begin
    w_op_b  = bus.ReadData2;
    w_fwd_b = C_SEL_RF;
    if (w_ex_hit_b) begin
      w_op_b  = w_ex_val;
      w_fwd_b = C_SEL_EX;
    end else if (w_mem_hit_b) begin
      w_op_b  = w_mem_val;
      w_fwd_b = C_SEL_MEM;
    end
  end

  // Pipeline register: flush inserts a bubble (data fields kept), stall holds.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_valid   <= 1'b0;
      r_regwre  <= 1'b0;
      r_memread <= 1'b0;
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_imm     <= '0;
      r_pc      <= '0;
      r_ctrl    <= '0;
      r_wreg    <= '0;
      r_fwd_a   <= C_SEL_RF;
      r_fwd_b   <= C_SEL_RF;
    end else if (bus.Flush) begin
      r_valid   <= 1'b0;
      r_regwre  <= 1'b0;
      r_memread <= 1'b0;
      r_ctrl    <= '0;
      r_fwd_a   <= C_SEL_RF;
      r_fwd_b   <= C_SEL_RF;
    end else if (!bus.Stall) begin
      r_valid   <= bus.InValid;
      r_regwre  <= bus.RegWreIn  && bus.InValid;
      r_memread <= bus.MemReadIn && bus.InValid;
      r_op_a    <= w_op_a;
      r_op_b    <= w_op_b;
      r_imm     <= bus.Imm;
      r_pc      <= bus.PcIn;
      r_ctrl    <= bus.CtrlIn;
      r_wreg    <= bus.WriteRegIn;
      r_fwd_a   <= w_fwd_a;
      r_fwd_b   <= w_fwd_b;
    end
  end

  assign bus.OutValid    = r_valid;
  assign bus.RegWreOut   = r_regwre;
  assign bus.MemReadOut  = r_memread;
  assign bus.OpA         = r_op_a;
  assign bus.OpB         = r_op_b;
  assign bus.ImmOut      = r_imm;
  assign bus.PcOut       = r_pc;
  assign bus.CtrlOut     = r_ctrl;
  assign bus.WriteRegOut = r_wreg;
  assign bus.FwdA        = r_fwd_a;
  assign bus.FwdB        = r_fwd_b;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Scoreboard bench for id_ex_stage with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

  localparam logic [3:0] C_REG0 = 4'h0;
  localparam logic [3:0] C_T    = 4'hE;
  localparam logic [3:0] C_PC   = 4'hF;

  typedef struct packed {
    logic        valid;
    logic [15:0] opa;
    logic [15:0] opb;
    logic [15:0] imm;
    logic [15:0] pc;
    logic [7:0]  ctrl;
    logic        regwre;
    logic        memread;
    logic [3:0]  wreg;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        lus;
  } obs_t;

  logic  Clk;
  logic  Rst;
  obs_t  exp_q[$];
  string name_q[$];
  obs_t  m;
  int    n_tests;
  int    n_fail;

  id_ex_stage_if #(.DATA_W(16), .CTRL_W(8)) bus ();

  id_ex_stage #(.DATA_W(16), .CTRL_W(8)) u_dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Pops one expectation per falling edge and compares the full EX slot plus
  // the combinational stall request of the vector currently applied.
  task automatic monitor();
    obs_t  a, e;
    string nm;
    forever begin
      @(negedge Clk);
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a.valid   = bus.OutValid;
        a.opa     = bus.OpA;
        a.opb     = bus.OpB;
        a.imm     = bus.ImmOut;
        a.pc      = bus.PcOut;
        a.ctrl    = bus.CtrlOut;
        a.regwre  = bus.RegWreOut;
        a.memread = bus.MemReadOut;
        a.wreg    = bus.WriteRegOut;
        a.fa      = bus.FwdA;
        a.fb      = bus.FwdB;
        a.lus     = bus.LoadUseStall;
        n_tests++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h (valid opa opb imm pc ctrl rw mr wreg fa fb lus)",
                   nm, a, e);
        end
      end
    end
  endtask

  task automatic idle();
    bus.Stall = 0; bus.Flush = 0; bus.InValid = 0;
    bus.Rs = 0; bus.Rt = 0; bus.ReadData1 = 0; bus.ReadData2 = 0;
    bus.Imm = 0; bus.CtrlIn = 0; bus.RegWreIn = 0; bus.WriteRegIn = 0;
    bus.MemReadIn = 0; bus.PcIn = 0;
    bus.ExRegWre = 0; bus.ExMemRead = 0; bus.ExWriteReg = 0; bus.ExResult = 0;
    bus.MemRegWre = 0; bus.MemWriteReg = 0; bus.MemResult = 0;
  endtask

  // Push the expected view for the coming falling edge (slot from previous
  // vector, stall request of this one), then advance the slot model using the
  // hand-computed operands/selects for this vector.
  task automatic step(input string nm,
                      input logic [15:0] e_opa, input logic [1:0] e_fa,
                      input logic [15:0] e_opb, input logic [1:0] e_fb,
                      input logic e_lus);
    obs_t e;
    if (!Rst) m = '0;
    e     = m;
    e.lus = e_lus;
    exp_q.push_back(e);
    name_q.push_back(nm);
    if (!Rst) begin
      m = '0;
    end else if (bus.Flush) begin
      m.valid = 0; m.regwre = 0; m.memread = 0; m.ctrl = 0; m.fa = 0; m.fb = 0;
    end else if (!bus.Stall) begin
      m.valid   = bus.InValid;
      m.opa     = e_opa;
      m.fa      = e_fa;
      m.opb     = e_opb;
      m.fb      = e_fb;
      m.imm     = bus.Imm;
      m.pc      = bus.PcIn;
      m.ctrl    = bus.CtrlIn;
      m.regwre  = bus.RegWreIn & bus.InValid;
      m.memread = bus.MemReadIn & bus.InValid;
      m.wreg    = bus.WriteRegIn;
    end
    @(posedge Clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m       = '0;
    Rst     = 1'b0;
    idle();
    fork
      monitor();
    join_none
    @(posedge Clk);
    #1;

    // Reset with busy inputs; InValid=0 so no stall request.
    idle(); Rst = 0;
    bus.ExMemRead = 1; bus.ExRegWre = 1; bus.ExWriteReg = 5; bus.Rs = 5;
    bus.ReadData1 = 16'hDEAD; bus.CtrlIn = 8'hFF; bus.RegWreIn = 1; bus.Imm = 16'h1234;
    step("reset", 16'h0, 2'd0, 16'h0, 2'd0, 1'b0);

    // EX beats MEM for Rs=3.
    idle(); Rst = 1;
    bus.InValid = 1; bus.Rs = 3; bus.ReadData1 = 16'h1111; bus.Rt = 4; bus.ReadData2 = 16'h2222;
    bus.ExRegWre = 1; bus.ExWriteReg = 3; bus.ExResult = 16'hABCD;
    bus.MemRegWre = 1; bus.MemWriteReg = 3; bus.MemResult = 16'h5555;
    bus.RegWreIn = 1; bus.WriteRegIn = 7; bus.Imm = 16'h0042; bus.PcIn = 16'h0100; bus.CtrlIn = 8'h5A;
    step("ex_fwd", 16'hABCD, 2'd2, 16'h2222, 2'd0, 1'b0);

    // MEM forward into T, zero result -> 1.
    idle();
    bus.InValid = 1; bus.Rs = 2; bus.ReadData1 = 16'h0202; bus.Rt = C_T; bus.ReadData2 = 16'h0BAD;
    bus.MemRegWre = 1; bus.MemWriteReg = C_T; bus.MemResult = 16'h0000;
    bus.PcIn = 16'h0102; bus.CtrlIn = 8'h11; bus.Imm = 16'hFFFE;
    step("mem_t_zero", 16'h0202, 2'd0, 16'h0001, 2'd1, 1'b0);

    // MEM forward into T, nonzero result -> 0.
    bus.MemResult = 16'h0007; bus.PcIn = 16'h0104;
    step("mem_t_nonzero", 16'h0202, 2'd0, 16'h0000, 2'd1, 1'b0);

    // REG0 and PC sources never forwarded.
    idle();
    bus.InValid = 1; bus.Rs = C_REG0; bus.ReadData1 = 16'h0000; bus.Rt = C_PC; bus.ReadData2 = 16'h0300;
    bus.ExRegWre = 1; bus.ExWriteReg = C_REG0; bus.ExResult = 16'hFFFF;
    bus.MemRegWre = 1; bus.MemWriteReg = C_PC; bus.MemResult = 16'h1234;
    bus.RegWreIn = 1; bus.WriteRegIn = 2; bus.PcIn = 16'h0106;
    step("no_fwd_reg0_pc", 16'h0000, 2'd0, 16'h0300, 2'd0, 1'b0);

    // EX forward into T (zero -> 1) and MEM forward on Rt.
    idle();
    bus.InValid = 1; bus.Rs = C_T; bus.ReadData1 = 16'h0000; bus.Rt = 6; bus.ReadData2 = 16'h0066;
    bus.ExRegWre = 1; bus.ExWriteReg = C_T; bus.ExResult = 16'h0000;
    bus.MemRegWre = 1; bus.MemWriteReg = 6; bus.MemResult = 16'h6060;
    bus.MemReadIn = 1; bus.RegWreIn = 1; bus.WriteRegIn = 6; bus.PcIn = 16'h0108; bus.CtrlIn = 8'hC3;
    step("ex_t_mem_b", 16'h0001, 2'd2, 16'h6060, 2'd1, 1'b0);

    // Load-use on Rt=5; hazard unit flushes this slot.
    idle();
    bus.InValid = 1; bus.Rs = 1; bus.Rt = 5; bus.ReadData1 = 16'h0111; bus.ReadData2 = 16'h0555;
    bus.ExMemRead = 1; bus.ExRegWre = 1; bus.ExWriteReg = 5; bus.ExResult = 16'h9999;
    bus.RegWreIn = 1; bus.WriteRegIn = 9; bus.CtrlIn = 8'h77; bus.Flush = 1;
    step("load_use_flush", 16'h0, 2'd0, 16'h0, 2'd0, 1'b1);

    // Load to REG0 must not raise a stall; plain capture.
    idle();
    bus.InValid = 1; bus.Rs = C_REG0; bus.Rt = C_REG0; bus.ReadData1 = 16'h0007; bus.ReadData2 = 16'h0008;
    bus.ExMemRead = 1; bus.ExRegWre = 1; bus.ExWriteReg = C_REG0; bus.ExResult = 16'hEEEE;
    bus.MemReadIn = 1; bus.RegWreIn = 1; bus.WriteRegIn = 3; bus.PcIn = 16'h010C; bus.CtrlIn = 8'h21;
    step("lu_reg0_none", 16'h0007, 2'd0, 16'h0008, 2'd0, 1'b0);

    // Load to PC must not raise a stall either.
    idle();
    bus.InValid = 1; bus.Rs = C_PC; bus.ReadData1 = 16'h010E; bus.Rt = 2; bus.ReadData2 = 16'h0022;
    bus.ExMemRead = 1; bus.ExRegWre = 1; bus.ExWriteReg = C_PC; bus.ExResult = 16'h4444;
    bus.RegWreIn = 1; bus.WriteRegIn = 4; bus.PcIn = 16'h010E; bus.CtrlIn = 8'h31;
    step("lu_pc_none", 16'h010E, 2'd0, 16'h0022, 2'd0, 1'b0);

    // Matching load but InValid=0: no stall, slot invalid, write gated.
    idle();
    bus.InValid = 0; bus.Rs = 5; bus.ReadData1 = 16'h0500;
    bus.ExMemRead = 1; bus.ExRegWre = 1; bus.ExWriteReg = 5; bus.ExResult = 16'h0055;
    bus.RegWreIn = 1; bus.MemReadIn = 1; bus.WriteRegIn = 5; bus.PcIn = 16'h0110; bus.CtrlIn = 8'h09;
    step("lu_invalid", 16'h0055, 2'd2, 16'h0000, 2'd0, 1'b0);

    // Plain instruction.
    idle();
    bus.InValid = 1; bus.Rs = 9; bus.ReadData1 = 16'h9999; bus.Rt = 10; bus.ReadData2 = 16'hAAAA;
    bus.RegWreIn = 1; bus.WriteRegIn = 11; bus.Imm = 16'h0080; bus.PcIn = 16'h0112; bus.CtrlIn = 8'h3C;
    step("plain", 16'h9999, 2'd0, 16'hAAAA, 2'd0, 1'b0);

    // Three stall cycles with changing inputs: slot holds.
    for (int i = 0; i < 3; i++) begin
      idle();
      bus.Stall = 1; bus.InValid = 1; bus.Rs = 4'(i + 1); bus.ReadData1 = 16'(16'h7000 + i);
      bus.RegWreIn = 1; bus.MemReadIn = 1; bus.WriteRegIn = 4'(12 - i);
      bus.PcIn = 16'(16'h0200 + i); bus.CtrlIn = 8'(8'hE0 + i); bus.Imm = 16'hBEEF;
      step("stall_hold", 16'h0, 2'd0, 16'h0, 2'd0, 1'b0);
    end

    // Stall and flush together: bubble wins.
    idle();
    bus.Stall = 1; bus.Flush = 1; bus.InValid = 1; bus.RegWreIn = 1; bus.CtrlIn = 8'hAA;
    step("stall_hold_last", 16'h0, 2'd0, 16'h0, 2'd0, 1'b0);

    // Release: new instruction captured with forwards on both operands.
    idle();
    bus.InValid = 1; bus.Rs = 1; bus.ReadData1 = 16'h0101; bus.Rt = 2; bus.ReadData2 = 16'h0202;
    bus.ExRegWre = 1; bus.ExWriteReg = 1; bus.ExResult = 16'h7777;
    bus.MemRegWre = 1; bus.MemWriteReg = 2; bus.MemResult = 16'h2020;
    bus.RegWreIn = 1; bus.WriteRegIn = 8; bus.Imm = 16'h0010; bus.PcIn = 16'h0300; bus.CtrlIn = 8'h42;
    step("stall_flush_bubble", 16'h7777, 2'd2, 16'h2020, 2'd1, 1'b0);

    // Mid-operation reset clears the slot at once.
    idle();
    bus.InValid = 1; bus.Rs = 3; bus.ReadData1 = 16'h3333; bus.RegWreIn = 1; bus.CtrlIn = 8'h99;
    step("release_capture", 16'h3333, 2'd0, 16'h0000, 2'd0, 1'b0);
    Rst = 0;
    step("midop_reset", 16'h0, 2'd0, 16'h0, 2'd0, 1'b0);

    // Leave reset and let the final expectations drain.
    idle(); Rst = 1;
    step("after_reset", 16'h0, 2'd0, 16'h0, 2'd0, 1'b0);
    step("final_idle", 16'h0, 2'd0, 16'h0, 2'd0, 1'b0);

    for (int k = 0; k < 5 && exp_q.size() != 0; k++) @(posedge Clk);
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
